test_monitor: RTL and testbench

TEST_MONITOR -- requirements
Module: test_monitor

---
 rtl/test_monitor.sv | 174 +++++++++++++++++
 tb/tb_test_monitor.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_monitor.sv
// test_monitor: aggregates per-channel done/result flags from several test
// modules into a single registered completion verdict. It tracks the fail
// count and the first failing channel, and forces a failing completion when
// the cycle budget runs out before every channel has reported.
module test_monitor #(
    parameter int NUM_TESTS      = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_TESTS-1:0] test_done,
    input  logic [NUM_TESTS-1:0] test_result,
    output logic                 done,
    output logic                 result,
    output logic [4:0]           fail_count,
    output logic                 first_fail_valid,
    output logic [3:0]           first_fail_idx,
    output logic                 timed_out,
    output logic [CNT_W-1:0]     cycle_count
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    // Cycle count value at which the run is forced to finish.
    localparam logic [63:0]      TO_LIMIT = 64'(TIMEOUT_CYCLES) - 64'd1;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_FINISH = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_TESTS-1:0] seen_q, seen_d;
    logic                 done_q, done_d;
    logic                 result_q, result_d;
    logic [4:0]           fail_cnt_q, fail_cnt_d;
    logic                 ff_valid_q, ff_valid_d;
    logic [3:0]           ff_idx_q, ff_idx_d;
    logic                 timed_out_q, timed_out_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [NUM_TESTS-1:0] new_seen_s;
    logic [NUM_TESTS-1:0] new_fail_s;
    logic [4:0]           new_fail_cnt_s;
    logic                 all_seen_s;
    logic                 timeout_s;

    // Number of set bits: several channels may fail on the same edge.
    function automatic logic [4:0] count_ones(input logic [NUM_TESTS-1:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < NUM_TESTS; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    // Lowest set index: simultaneous fails report the lowest channel.
    function automatic logic [3:0] lowest_index(input logic [NUM_TESTS-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = NUM_TESTS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // Next-state logic: sample newly done channels, count, and decide completion.
    always_comb begin
        state_d        = state_q;
        seen_d         = seen_q;
        done_d         = done_q;
        result_d       = result_q;
        fail_cnt_d     = fail_cnt_q;
        ff_valid_d     = ff_valid_q;
        ff_idx_d       = ff_idx_q;
        timed_out_d    = timed_out_q;
        cnt_d          = cnt_q;
        new_seen_s     = '0;
        new_fail_s     = '0;
        new_fail_cnt_s = 5'd0;
        all_seen_s     = 1'b0;
        timeout_s      = 1'b0;

        case (state_q)
            ST_RUN: begin
                // Only the first done edge of a channel samples its result.
                new_seen_s     = test_done & ~seen_q;
                new_fail_s     = new_seen_s & ~test_result;
                new_fail_cnt_s = count_ones(new_fail_s);
                seen_d         = seen_q | new_seen_s;
                fail_cnt_d     = fail_cnt_q + new_fail_cnt_s;

                if (!ff_valid_q && (new_fail_s != '0)) begin
                    ff_valid_d = 1'b1;
                    ff_idx_d   = lowest_index(new_fail_s);
                end else begin
                    ff_valid_d = ff_valid_q;
                    ff_idx_d   = ff_idx_q;
                end

                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end

                all_seen_s = &seen_d;
                timeout_s  = (64'(cnt_d) >= TO_LIMIT);

                // Completion wins over a timeout landing on the same edge.
                if (all_seen_s) begin
                    state_d     = ST_FINISH;
                    done_d      = 1'b1;
                    result_d    = (fail_cnt_d == 5'd0);
                    timed_out_d = 1'b0;
                end else if (timeout_s) begin
                    state_d     = ST_FINISH;
                    done_d      = 1'b1;
                    result_d    = 1'b0;
                    timed_out_d = 1'b1;
                end else begin
                    state_d     = ST_RUN;
                    done_d      = 1'b0;
                    result_d    = 1'b0;
                    timed_out_d = 1'b0;
                end
            end
            ST_FINISH: begin
                // Absorbing: everything stays frozen until reset.
                state_d = ST_FINISH;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            seen_q      <= '0;
            done_q      <= 1'b0;
            result_q    <= 1'b0;
            fail_cnt_q  <= 5'd0;
            ff_valid_q  <= 1'b0;
            ff_idx_q    <= 4'd0;
            timed_out_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            seen_q      <= seen_d;
            done_q      <= done_d;
            result_q    <= result_d;
            fail_cnt_q  <= fail_cnt_d;
            ff_valid_q  <= ff_valid_d;
            ff_idx_q    <= ff_idx_d;
            timed_out_q <= timed_out_d;
            cnt_q       <= cnt_d;
        end
    end

    assign done             = done_q;
    assign result           = result_q;
    assign fail_count       = fail_cnt_q;
    assign first_fail_valid = ff_valid_q;
    assign first_fail_idx   = ff_idx_q;
    assign timed_out        = timed_out_q;
    assign cycle_count      = cnt_q;

endmodule

// File: tb/tb_test_monitor.sv
// tb_test_monitor: drives three monitor instances (default, short timeout,
// narrow saturating counter) with the same per-cycle stimulus and compares
// every output, every cycle, with a schedule-based reference model.
module tb_test_monitor;

    localparam int NT   = 4;
    localparam int MAXL = 64;
    localparam int INF  = 1 << 30;

    logic          clk         = 1'b0;
    logic          rst_n       = 1'b0;
    logic [NT-1:0] test_done   = '0;
    logic [NT-1:0] test_result = '0;

    logic       done_w   [3];
    logic       result_w [3];
    logic       ffv_w    [3];
    logic       to_w     [3];
    logic [4:0] fc_w     [3];
    logic [3:0] ffi_w    [3];
    logic [19:0] cc_a;
    logic [19:0] cc_b;
    logic [2:0]  cc_c;

    int checks = 0;
    int errors = 0;

    // Stimulus schedule: value of test_done/test_result during cycle k.
    logic [NT-1:0] sd [MAXL];
    logic [NT-1:0] sr [MAXL];
    int            slen;

    int tmo_v  [3] = '{1000, 8, 1000};
    int cmax_v [3] = '{(1 << 20) - 1, (1 << 20) - 1, 7};

    typedef struct {
        int done;
        int result;
        int fc;
        int ffv;
        int ffi;
        int to;
        int cc;
    } exp_t;

    always #5 clk = ~clk;

    test_monitor #(.NUM_TESTS(NT)) dut_a (
        .clk(clk), .rst_n(rst_n), .test_done(test_done), .test_result(test_result),
        .done(done_w[0]), .result(result_w[0]), .fail_count(fc_w[0]),
        .first_fail_valid(ffv_w[0]), .first_fail_idx(ffi_w[0]),
        .timed_out(to_w[0]), .cycle_count(cc_a)
    );

    test_monitor #(.NUM_TESTS(NT), .TIMEOUT_CYCLES(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .test_done(test_done), .test_result(test_result),
        .done(done_w[1]), .result(result_w[1]), .fail_count(fc_w[1]),
        .first_fail_valid(ffv_w[1]), .first_fail_idx(ffi_w[1]),
        .timed_out(to_w[1]), .cycle_count(cc_b)
    );

    test_monitor #(.NUM_TESTS(NT), .CNT_W(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .test_done(test_done), .test_result(test_result),
        .done(done_w[2]), .result(result_w[2]), .fail_count(fc_w[2]),
        .first_fail_valid(ffv_w[2]), .first_fail_idx(ffi_w[2]),
        .timed_out(to_w[2]), .cycle_count(cc_c)
    );

    // Expected outputs after n clock edges, from the done schedule alone:
    // each channel reports at its first done cycle; the run ends at the last
    // report or at the timeout edge, whichever comes first (report wins ties).
    function automatic exp_t model(input int n, input int tmo, input int cmax);
        exp_t e;
        int   dc [NT];
        int   c_last, tc, fin, last, best;
        bit   to;
        c_last = 0;
        for (int ch = 0; ch < NT; ch++) begin
            dc[ch] = INF;
            for (int k = 0; k < slen; k++) begin
                if (sd[k][ch] && dc[ch] == INF) dc[ch] = k;
            end
            if (dc[ch] > c_last) c_last = dc[ch];
        end
        tc = (tmo - 1 <= cmax) ? tmo - 2 : INF;
        if (c_last <= tc) begin
            fin = c_last;
            to  = 1'b0;
        end else begin
            fin = tc;
            to  = 1'b1;
        end
        last  = (n - 1 < fin) ? n - 1 : fin;
        e.fc  = 0;
        e.ffv = 0;
        e.ffi = 0;
        best  = INF;
        for (int ch = 0; ch < NT; ch++) begin
            if (dc[ch] <= last) begin
                if (!sr[dc[ch]][ch]) begin
                    e.fc++;
                    if (dc[ch] < best) begin
                        best  = dc[ch];
                        e.ffi = ch;
                        e.ffv = 1;
                    end
                end
            end
        end
        e.done   = (n > fin) ? 1 : 0;
        e.to     = (e.done != 0 && to) ? 1 : 0;
        e.result = (e.done != 0 && !to && e.fc == 0) ? 1 : 0;
        e.cc     = n;
        if (fin + 1 < e.cc) e.cc = fin + 1;
        if (cmax < e.cc) e.cc = cmax;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cc_of(input int d);
        if (d == 0) return {12'd0, cc_a};
        else if (d == 1) return {12'd0, cc_b};
        else return {29'd0, cc_c};
    endfunction

    task automatic check_all(input string name, input int n);
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            e = model(n, tmo_v[d], cmax_v[d]);
            chk($sformatf("%s n%0d d%0d done", name, n, d), 32'(done_w[d]), e.done);
            chk($sformatf("%s n%0d d%0d result", name, n, d), 32'(result_w[d]), e.result);
            chk($sformatf("%s n%0d d%0d fail_count", name, n, d), 32'(fc_w[d]), e.fc);
            chk($sformatf("%s n%0d d%0d ff_valid", name, n, d), 32'(ffv_w[d]), e.ffv);
            chk($sformatf("%s n%0d d%0d ff_idx", name, n, d), 32'(ffi_w[d]), e.ffi);
            chk($sformatf("%s n%0d d%0d timed_out", name, n, d), 32'(to_w[d]), e.to);
            chk($sformatf("%s n%0d d%0d cycle_count", name, n, d), cc_of(d), e.cc);
        end
    endtask

    // Assert reset between clock edges, check the asynchronous clear, then
    // release on a falling edge with junk driven on the inputs meanwhile.
    task automatic do_reset(input string name);
        #2;
        rst_n       = 1'b0;
        test_done   = NT'($urandom);
        test_result = NT'($urandom);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s rst d%0d done", name, d), 32'(done_w[d]), 32'd0);
            chk($sformatf("%s rst d%0d result", name, d), 32'(result_w[d]), 32'd0);
            chk($sformatf("%s rst d%0d fail_count", name, d), 32'(fc_w[d]), 32'd0);
            chk($sformatf("%s rst d%0d ff_valid", name, d), 32'(ffv_w[d]), 32'd0);
            chk($sformatf("%s rst d%0d ff_idx", name, d), 32'(ffi_w[d]), 32'd0);
            chk($sformatf("%s rst d%0d timed_out", name, d), 32'(to_w[d]), 32'd0);
            chk($sformatf("%s rst d%0d cycle_count", name, d), cc_of(d), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run(input string name, input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            test_done   = sd[k];
            test_result = sr[k];
            @(posedge clk);
            @(negedge clk);
            check_all(name, k + 1);
        end
    endtask

    task automatic clear_stim(input int len);
        slen = len;
        for (int k = 0; k < MAXL; k++) begin
            sd[k] = '0;
            sr[k] = '0;
        end
    endtask

    task automatic set_ch(input int ch, input int start, input bit res);
        for (int k = start; k < slen; k++) begin
            sd[k][ch] = 1'b1;
            sr[k][ch] = res;
        end
    endtask

    initial begin
        // All pass: channels done at cycles 3, 5, 5, 9.
        clear_stim(14);
        set_ch(0, 3, 1'b1); set_ch(1, 5, 1'b1); set_ch(2, 5, 1'b1); set_ch(3, 9, 1'b1);
        do_reset("allpass");
        run("allpass", slen);
        chk("allpass done", 32'(done_w[0]), 32'd1);
        chk("allpass result", 32'(result_w[0]), 32'd1);
        chk("allpass fail_count", 32'(fc_w[0]), 32'd0);
        chk("allpass timed_out", 32'(to_w[0]), 32'd0);
        chk("allpass cycle_count", cc_of(0), 32'd10);

        // Simultaneous fails on channels 2 and 1, then channel 0.
        clear_stim(12);
        set_ch(1, 2, 1'b0); set_ch(2, 2, 1'b0); set_ch(0, 4, 1'b0); set_ch(3, 6, 1'b1);
        do_reset("simfail");
        run("simfail", slen);
        chk("simfail fail_count", 32'(fc_w[0]), 32'd3);
        chk("simfail ff_idx", 32'(ffi_w[0]), 32'd1);
        chk("simfail ff_valid", 32'(ffv_w[0]), 32'd1);
        chk("simfail result", 32'(result_w[0]), 32'd0);

        // Timeout: channel 3 never reports (short-timeout instance).
        clear_stim(12);
        set_ch(0, 1, 1'b1); set_ch(1, 1, 1'b1); set_ch(2, 1, 1'b1);
        do_reset("timeout");
        run("timeout", slen);
        chk("timeout done", 32'(done_w[1]), 32'd1);
        chk("timeout timed_out", 32'(to_w[1]), 32'd1);
        chk("timeout result", 32'(result_w[1]), 32'd0);
        chk("timeout cycle_count", cc_of(1), 32'd7);

        // Tie: last done arrives on the timeout edge.
        clear_stim(12);
        set_ch(0, 1, 1'b1); set_ch(1, 1, 1'b1); set_ch(2, 1, 1'b1); set_ch(3, 6, 1'b1);
        do_reset("tie");
        run("tie", slen);
        chk("tie timed_out", 32'(to_w[1]), 32'd0);
        chk("tie result", 32'(result_w[1]), 32'd1);
        chk("tie cycle_count", cc_of(1), 32'd7);

        // Sticky sample: channel 0 result drops while done stays high.
        clear_stim(10);
        set_ch(0, 1, 1'b1);
        for (int k = 3; k < slen; k++) sr[k][0] = 1'b0;
        set_ch(1, 2, 1'b1); set_ch(2, 2, 1'b1); set_ch(3, 4, 1'b1);
        do_reset("sticky");
        run("sticky", slen);
        chk("sticky result", 32'(result_w[0]), 32'd1);
        chk("sticky fail_count", 32'(fc_w[0]), 32'd0);

        // Mid-run reset at cycle 4, then a full rerun of the all-pass case.
        clear_stim(14);
        set_ch(0, 3, 1'b1); set_ch(1, 5, 1'b1); set_ch(2, 5, 1'b1); set_ch(3, 9, 1'b1);
        do_reset("midrst");
        run("midrst", 4);
        do_reset("midrst2");
        run("midrst2", slen);
        chk("midrst done", 32'(done_w[0]), 32'd1);
        chk("midrst result", 32'(result_w[0]), 32'd1);
        chk("midrst cycle_count", cc_of(0), 32'd10);

        // Random schedules: done bits toggle freely, results vary every cycle.
        for (int s = 0; s < 25; s++) begin
            clear_stim(20);
            for (int ch = 0; ch < NT; ch++) begin
                bit never;
                never = ($urandom_range(0, 7) == 0);
                for (int k = 0; k < slen; k++) begin
                    sd[k][ch] = !never && ($urandom_range(0, 3) == 0);
                    if (s % 2 == 1) sr[k][ch] = ($urandom_range(0, 7) != 0);
                    else sr[k][ch] = 1'($urandom_range(0, 1));
                end
            end
            do_reset($sformatf("rnd%0d", s));
            run($sformatf("rnd%0d", s), slen);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
